// File: rtl/comp_pkg.sv
// Shared encodings for the serial magnitude comparator: one-hot {x,y,z} result
// codes and the controller state type.
package comp_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/comp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice, one-hot {gt,lt,eq}.
module comp_chunk
    import comp_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] ca,
    input  logic [CHUNK-1:0] cb,
    output logic [2:0]       res
);

    // Chunk ordering
    always_comb begin
        res = CMP_EQ;
        if (ca > cb) begin
            res = CMP_GT;
        end else if (ca < cb) begin
            res = CMP_LT;
        end else begin
            res = CMP_EQ;
        end
    end

endmodule

// File: rtl/comp_serial.sv
// Multi-cycle MSB-first magnitude comparator with early exit.
// Optional COMP_SERIAL_SIGNED_EN: two's complement operands via sign-bit flip at capture.
module comp_serial
    import comp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 2,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic [CW-1:0]    nchk
);

    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t                        state_r, state_s;
    logic [WIDTH-1:0]              a_r, b_r, a_cap_s, b_cap_s;
    logic [CW-1:0]                 idx_r, nchk_r;
    logic [2:0]                    res_r, res_s;
    logic                          busy_r, done_r, accept_s, finish_s;
    logic [NCHUNK-1:0][CHUNK-1:0]  ach_s, bch_s;
    logic [IW-1:0]                 sel_s;

`ifdef COMP_SERIAL_SIGNED_EN
    // Flipping the sign bit maps two's complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    assign a_cap_s = a ^ SIGN_MASK;
    assign b_cap_s = b ^ SIGN_MASK;
`else
    assign a_cap_s = a;
    assign b_cap_s = b;
`endif

    assign ach_s = a_r;
    assign bch_s = b_r;
    assign sel_s = idx_r[IW-1:0];

    comp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .ca  (ach_s[sel_s]),
        .cb  (bch_s[sel_s]),
        .res (res_s)
    );

    // Next-state and handshake decode
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if ((res_s != CMP_EQ) || (idx_r == {CW{1'b0}})) begin
                    finish_s = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    state_s  = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, operand capture, chunk index and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            idx_r   <= {CW{1'b0}};
            nchk_r  <= {CW{1'b0}};
            res_r   <= 3'b000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_RUN);
            done_r  <= (state_s == ST_DONE);
            if (accept_s) begin
                a_r    <= a_cap_s;
                b_r    <= b_cap_s;
                idx_r  <= CW'(NCHUNK - 1);
                nchk_r <= {CW{1'b0}};
                res_r  <= 3'b000;
            end else if (finish_s) begin
                res_r  <= res_s;
                nchk_r <= CW'(NCHUNK) - idx_r;
            end else if (state_r == ST_RUN) begin
                idx_r  <= idx_r - CW'(1);
            end else begin
                idx_r  <= idx_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign x    = res_r[2];
    assign y    = res_r[1];
    assign z    = res_r[0];
    assign nchk = nchk_r;

endmodule

// File: tb/tb_comp_serial.sv
// Randomized self-checking bench for comp_serial against a transaction-level model.
module tb_comp_serial;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 2;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [WIDTH-1:0]  a, b;
    logic              busy, done, x, y, z;
    logic [CW-1:0]     nchk;

    int checks = 0;
    int errors = 0;

    int         m_left;
    logic       m_done;
    logic [2:0] m_res, m_pres;
    int         m_nchk, m_pk;

    comp_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .x     (x),
        .y     (y),
        .z     (z),
        .nchk  (nchk)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_res(logic [WIDTH-1:0] av, logic [WIDTH-1:0] bv);
`ifdef COMP_SERIAL_SIGNED_EN
        if ($signed(av) > $signed(bv)) return 3'b100;
        if ($signed(av) < $signed(bv)) return 3'b010;
`else
        if (av > bv) return 3'b100;
        if (av < bv) return 3'b010;
`endif
        return 3'b001;
    endfunction

    // Chunks examined = chunks down to and including the one holding the top differing bit.
    function automatic int ref_k(logic [WIDTH-1:0] av, logic [WIDTH-1:0] bv);
        logic [WIDTH-1:0] d;
        d = av ^ bv;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (d[i]) return NCHUNK - i / CHUNK;
        end
        return NCHUNK;
    endfunction

    // Model: an accepted start schedules the result k edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= 3'b000;
            m_pres <= 3'b000;
            m_nchk <= 0;
            m_pk   <= 0;
        end else if (start && m_left == 0) begin
            m_left <= ref_k(a, b);
            m_pk   <= ref_k(a, b);
            m_pres <= ref_res(a, b);
            m_res  <= 3'b000;
            m_nchk <= 0;
            m_done <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_res  <= m_pres;
                m_nchk <= m_pk;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
        chk("busy", int'(busy), int'(m_left != 0));
        chk("done", int'(done), int'(m_done));
        chk("xyz", int'({x, y, z}), int'(m_res));
        chk("nchk", int'(nchk), m_nchk);
    endtask

    task automatic do_cmp(string tag, logic [WIDTH-1:0] av, logic [WIDTH-1:0] bv,
                          logic [2:0] eres, int ek);
        int n;
        int nb;
        a = av;
        b = bv;
        start = 1'b1;
        tick;
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        chk({tag, " clr_xyz"}, int'({x, y, z}), 0);
        chk({tag, " clr_nchk"}, int'(nchk), 0);
        chk({tag, " run"}, int'(busy), 1);
        n  = 0;
        nb = int'(busy);
        while (!done && n < 40) begin
            tick;
            n++;
            if (busy) nb++;
        end
        chk({tag, " latency"}, n, ek);
        chk({tag, " busy_cycles"}, nb, ek);
        chk({tag, " res"}, int'({x, y, z}), int'(eres));
        chk({tag, " nchk_lit"}, int'(nchk), ek);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        tick;
        tick;
        chk("rst busy", int'(busy), 0);
        chk("rst xyz", int'({x, y, z}), 0);
        chk("rst nchk", int'(nchk), 0);
        rst_n = 1'b1;
        tick;

        // Reset mid-compare aborts with all outputs low.
        a = 16'h1234; b = 16'h1234; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst xyz", int'({x, y, z}), 0);
        chk("midrst nchk", int'(nchk), 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("postrst idle", int'(busy), 0);

        do_cmp("eq", 16'hA5A5, 16'hA5A5, 3'b001, 8);
        tick;
`ifdef COMP_SERIAL_SIGNED_EN
        do_cmp("top", 16'h8000, 16'h0000, 3'b010, 1);
`else
        do_cmp("top", 16'h8000, 16'h0000, 3'b100, 1);
`endif
        tick;
        do_cmp("low", 16'h0001, 16'h0002, 3'b010, 8);
        tick;

        // Start during RUN must not disturb captured operands.
        a = 16'h00FF; b = 16'h00FE; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        a = 16'h0000; b = 16'hFFFF; start = 1'b1;
        tick;
        start = 1'b0;
        n = 3;
        while (!done && n < 40) begin
            tick;
            n++;
        end
        chk("ign latency", n, 8);
        chk("ign res", int'({x, y, z}), 3'b100);
        chk("ign nchk", int'(nchk), 8);

        // Back-to-back: accept directly in the DONE cycle.
        do_cmp("b2b", 16'h0005, 16'h0005, 3'b001, 8);
        tick;
        chk("idle after done", int'(busy), 0);

        for (int i = 0; i < 1500; i++) begin
            logic [WIDTH-1:0] r;
            r = WIDTH'($urandom);
            a = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = r;
                2: b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: b = a ^ (r & 16'h000F);
            endcase
            start = ($urandom_range(0, 2) == 0);
            tick;
        end
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
